prog_mem_loadable: RTL and testbench
====================================

// Module: prog_mem_loadable
// PURPOSE
//  Parametrised, writable program memory for the PIC-style core; replaces fixed case-table ROM.
//  Instruction words are loaded at boot (or reload) over a valid/ready stream, then served on a
//  registered fetch port. Core is held via 'halt' until a complete image has been loaded.
// PARAMETERS
//  DATA_W   14       instruction word width
//  ADDR_W   11       fetch/load address width
//  DEPTH    2048     words implemented (<= 2**ADDR_W); addresses >= DEPTH are unmapped
//  NOP_WORD 14'h0000 word returned for unmapped/blocked/errored fetches
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  ld_start   in   1       pulse: begin (re)load at address 0
//  ld_valid   in   1       ld_data valid
//  ld_data    in   DATA_W  instruction word to store
//  ld_last    in   1       qualifies final word of image (with ld_valid)
//  ld_ready   out  1       memory accepts word this cycle
//  ld_err     out  1       sticky: word offered past DEPTH-1 (dropped)
//  halt       out  1       core must stall; high unless state RUN
//  fetch_req  in   1       fetch request
//  fetch_addr in   ADDR_W  program counter
//  fetch_data out  DATA_W  registered instruction
//  fetch_vld  out  1       fetch_data valid (1-cycle latency)
//  par_err    out  1       sticky parity error (PROG_MEM_PARITY_EN only; else tied 0)
// BEHAVIOUR
//  Reset values: state=IDLE, ld_ready=0, ld_err=0, halt=1, fetch_data=NOP_WORD, fetch_vld=0,
//   par_err=0, wr_ptr=0. Array contents are NOT reset.
//  FSM IDLE -> LOAD on ld_start; LOAD -> RUN when ld_valid&ld_ready&ld_last; RUN -> LOAD on
//   ld_start (reload); ld_start in LOAD restarts at wr_ptr=0 and clears ld_err.
//  LOAD: ld_ready=1; word written at wr_ptr on ld_valid&ld_ready, wr_ptr++ (ADDR_W+1 bits, no wrap).
//   wr_ptr>=DEPTH: word dropped, ld_err set; ld_last still completes to RUN.
//  ld_start has priority over a simultaneous ld_valid beat (beat discarded).
//  RUN: fetch_req in cycle N -> fetch_data/fetch_vld valid in N+1. fetch_vld=fetch_req delayed 1.
//   fetch_addr>=DEPTH -> fetch_data=NOP_WORD, fetch_vld=1.
//  Not RUN: fetch_req ignored, fetch_vld=0, fetch_data holds NOP_WORD.
//  Entering LOAD from RUN: halt rises same edge; an in-flight fetch still completes next cycle.
//  Write and fetch never overlap (fetch blocked outside RUN); no read-during-write rule needed.
//  Async reset mid-load: image invalid, returns to IDLE, new ld_start required.
// CONFIGURATION
//  PROG_MEM_PARITY_EN defined: array is DATA_W+1 wide; even parity generated on write, checked on
//   fetch; mismatch -> fetch_data=NOP_WORD, fetch_vld=1, par_err set (cleared only by rst_n).
//  Undefined: array DATA_W wide, no check, par_err tied 0.
// STRUCTURE
//  Shared package pic_pkg: DATA_W/ADDR_W defaults, NOP_WORD, opcode constants, state enum
//   {IDLE, LOAD, RUN}.
//  One sub-module: prog_mem_array (sync write, registered read, width param) for RAM inference.
// TESTING
//  1 Reset only, fetch_req=1 addr 0 -> halt=1, fetch_vld=0, fetch_data=14'h0000.
//  2 Load 3 words 30FE,00A5,3002 (last on 3rd) -> RUN, halt=0; fetch addr 1 -> next cycle 14'h00A5, vld=1.
//  3 DEPTH=4, load 6 words -> ld_err=1 after 5th beat, words 0-3 intact, fetch addr 5 -> 14'h0000.
//  4 In RUN pulse ld_start with ld_valid -> beat discarded, halt=1 same edge, reload overwrites addr 0.
//  5 rst_n low mid-load (2 of 4 beats) -> state IDLE, halt=1, ld_ready=0 immediately (async).
//  6 PARITY_EN: force flip bit 3 of word 2, fetch addr 2 -> 14'h0000, vld=1, par_err=1 sticky.

Source files
------------

// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the PIC-style core and its loadable program memory:
// default geometry, the NOP instruction word, a few opcode field constants,
// and the program-memory control state enum.
// -----------------------------------------------------------------------------
package pic_pkg;

    localparam int PIC_DATA_W = 14;
    localparam int PIC_ADDR_W = 11;
    localparam int PIC_DEPTH  = 2048;

    // All-zero word decodes as NOP on the 14-bit core.
    localparam logic [PIC_DATA_W-1:0] PIC_NOP_WORD = 14'h0000;

    // Opcode fields, left-aligned in the 14-bit instruction word.
    localparam logic [5:0] OP_MOVLW = 6'b11_0000;   // 11 0000 kkkk kkkk
    localparam logic [2:0] OP_GOTO  = 3'b101;       // 101 kkk kkkk kkkk
    localparam logic [2:0] OP_CALL  = 3'b100;       // 100 kkk kkkk kkkk
    localparam logic [6:0] OP_MOVWF = 7'b000_0001;  // 00 0000 1fff ffff

    // IDLE : no valid image, core halted
    // LOAD : accepting image words over the load stream
    // RUN  : image complete, fetches served
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } pm_state_e;

endpackage : pic_pkg

// File: rtl/prog_mem_array.sv
// -----------------------------------------------------------------------------
// prog_mem_array
// Simple dual-port storage: one synchronous write port, one read port with a
// registered output. Contents and the read register are deliberately not reset
// so the array maps onto block RAM.
//
// Ports
//  clk      in   1      rising-edge clock
//  we_i     in   1      write enable
//  waddr_i  in   AW     write address
//  wdata_i  in   WIDTH  write data
//  re_i     in   1      read enable (updates rdata_o on the next edge)
//  raddr_i  in   AW     read address
//  rdata_o  out  WIDTH  registered read data
// -----------------------------------------------------------------------------
module prog_mem_array #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 2048,
    parameter int AW    = 11
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : prog_mem_array

// File: rtl/prog_mem_loadable.sv
// -----------------------------------------------------------------------------
// prog_mem_loadable
// Writable program memory for the PIC-style core. An instruction image is
// streamed in over a valid/ready interface after ld_start, then served on a
// one-cycle-latency fetch port. The core is held via halt until the final
// image word (ld_last) has been accepted.
//
// Optional build macro: PROG_MEM_PARITY_EN
//  defined   : array stores an extra even-parity bit per word; a fetch whose
//              stored word fails parity returns NOP_WORD and sets par_err
//              (sticky until rst_n).
//  undefined : no parity storage or check, par_err tied low.
//
// Ports
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  ld_start    in   1       pulse: begin (re)load at address 0
//  ld_valid    in   1       ld_data valid
//  ld_data     in   DATA_W  instruction word to store
//  ld_last     in   1       marks final word of image (with ld_valid)
//  ld_ready    out  1       word accepted this cycle (state LOAD)
//  ld_err      out  1       sticky: a word beyond DEPTH-1 was offered and dropped
//  halt        out  1       core stall, high unless state RUN
//  fetch_req   in   1       fetch request
//  fetch_addr  in   ADDR_W  program counter
//  fetch_data  out  DATA_W  registered instruction word
//  fetch_vld   out  1       fetch_data valid, fetch_req delayed one cycle in RUN
//  par_err     out  1       sticky parity error (parity build only)
// -----------------------------------------------------------------------------
module prog_mem_loadable
    import pic_pkg::*;
#(
    parameter int                 DATA_W   = PIC_DATA_W,
    parameter int                 ADDR_W   = PIC_ADDR_W,
    parameter int                 DEPTH    = PIC_DEPTH,
    parameter logic [DATA_W-1:0]  NOP_WORD = PIC_NOP_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              ld_err,
    output logic              halt,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_vld,
    output logic              par_err
);

`ifdef PROG_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    // Array address width follows DEPTH, not ADDR_W, so small memories do
    // not carry unused address bits into the RAM.
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH widened to the write-pointer width for range compares.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    // ---------------------------------------------------------------------
    // Declarations
    // ---------------------------------------------------------------------
    pm_state_e         state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;   // one extra bit: never wraps into range
    logic              ld_err_q, ld_err_d;
    logic              fetch_vld_q;
    logic              rd_ok_q;              // in-flight fetch targeted a mapped address

    logic              beat;                 // accepted load handshake
    logic              wr_full;
    logic              wr_en;
    logic              fetch_go;
    logic              fetch_hit;
    logic              par_bad;

    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rdata;

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ld_start wins over a coincident beat, so a restart never completes on
    // the same cycle it is requested.
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                end else if (beat && ld_last) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs (decoded from the registered state so reset acts at once)
    // ---------------------------------------------------------------------
    always_comb begin
        ld_ready = 1'b0;
        halt     = 1'b1;
        unique case (state_q)
            ST_LOAD: begin
                ld_ready = 1'b1;
            end
            ST_RUN: begin
                halt = 1'b0;
            end
            default: begin
                ld_ready = 1'b0;
                halt     = 1'b1;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Load path
    // ---------------------------------------------------------------------
    assign beat    = ld_ready & ld_valid & ~ld_start;
    assign wr_full = (wr_ptr_q >= DEPTH_L);
    assign wr_en   = beat & ~wr_full;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        ld_err_d = ld_err_q;
        if (ld_start) begin
            wr_ptr_d = '0;
            ld_err_d = 1'b0;
        end else if (beat) begin
            if (wr_full) begin
                ld_err_d = 1'b1;
            end
            // Saturate rather than wrap so an oversized image can never
            // alias back onto low addresses.
            if (wr_ptr_q != '1) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Fetch path
    // ---------------------------------------------------------------------
    assign fetch_go  = fetch_req & (state_q == ST_RUN);
    assign fetch_hit = fetch_go & ({1'b0, fetch_addr} < DEPTH_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            ld_err_q    <= 1'b0;
            fetch_vld_q <= 1'b0;
            rd_ok_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            ld_err_q    <= ld_err_d;
            fetch_vld_q <= fetch_go;
            rd_ok_q     <= fetch_hit;
        end
    end

    // ---------------------------------------------------------------------
    // Optional parity
    // ---------------------------------------------------------------------
`ifdef PROG_MEM_PARITY_EN
    logic par_err_q;

    // Stored word plus parity bit XOR to zero when intact.
    assign mem_wdata = {^ld_data, ld_data};
    assign par_bad   = rd_ok_q & (^mem_rdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else if (par_bad) begin
            par_err_q <= 1'b1;
        end
    end

    // Flag is visible in the same cycle as the poisoned fetch, then held.
    assign par_err = par_err_q | par_bad;
`else
    assign mem_wdata = ld_data;
    assign par_bad   = 1'b0;
    assign par_err   = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    prog_mem_array #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH),
        .AW    (MEM_AW)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[MEM_AW-1:0]),
        .wdata_i (mem_wdata),
        .re_i    (fetch_hit),
        .raddr_i (fetch_addr[MEM_AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // The RAM output register is not reset; rd_ok_q gates it so fetch_data
    // shows NOP_WORD after reset, outside RUN, for unmapped addresses and
    // for words failing parity.
    assign fetch_data = (rd_ok_q & ~par_bad) ? mem_rdata[DATA_W-1:0] : NOP_WORD;
    assign fetch_vld  = fetch_vld_q;
    assign ld_err     = ld_err_q;

endmodule : prog_mem_loadable

// File: tb/tb_prog_mem_loadable.sv
// -----------------------------------------------------------------------------
// tb_prog_mem_loadable
// Directed bench for prog_mem_loadable built with DEPTH=4 so that overflow of
// the image is cheap to reach. Expected fetch words go into a queue when a
// fetch is issued and are popped when fetch_vld is sampled.
// -----------------------------------------------------------------------------
module tb_prog_mem_loadable;
    import pic_pkg::*;

    localparam int DW    = 14;
    localparam int AW    = 11;
    localparam int DEPTH = 4;

    localparam logic [DW-1:0] IMG3 [6] = '{14'h1111, 14'h2222, 14'h0333,
                                            14'h3444, 14'h1555, 14'h2666};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          ld_ready;
    logic          ld_err;
    logic          halt;
    logic [DW-1:0] fetch_data;
    logic          fetch_vld;
    logic          par_err;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    prog_mem_loadable #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .DEPTH    (DEPTH),
        .NOP_WORD (PIC_NOP_WORD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_start   (ld_start),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .ld_err     (ld_err),
        .halt       (halt),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .fetch_vld  (fetch_vld),
        .par_err    (par_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
        $display("load start  halt=%b ld_ready=%b", halt, ld_ready);
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic last);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        $display("load beat   data=%h last=%b ld_err=%b halt=%b", d, last, ld_err, halt);
    endtask

    task automatic check_out(input string tag);
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk({tag, "_vld"}, 32'(fetch_vld), 32'd1);
        chk({tag, "_data"}, 32'(fetch_data), 32'(e));
        $display("fetch %s    data=%h vld=%b exp=%h", tag, fetch_data, fetch_vld, e);
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] e, input string tag);
        @(negedge clk);
        fetch_req  = 1'b1;
        fetch_addr = a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        check_out(tag);
    endtask

    initial begin
        // 1: reset, fetch requested while held
        fetch_req  = 1'b1;
        fetch_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_halt",     32'(halt),       32'd1);
        chk("rst_ld_ready", 32'(ld_ready),   32'd0);
        chk("rst_ld_err",   32'(ld_err),     32'd0);
        chk("rst_vld",      32'(fetch_vld),  32'd0);
        chk("rst_data",     32'(fetch_data), 32'h0000);
        chk("rst_par_err",  32'(par_err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_halt", 32'(halt),       32'd1);
        chk("idle_vld",  32'(fetch_vld),  32'd0);
        chk("idle_data", 32'(fetch_data), 32'h0000);
        fetch_req = 1'b0;

        // 2: three-word image
        start_load();
        chk("load_ready", 32'(ld_ready), 32'd1);
        chk("load_halt",  32'(halt),     32'd1);
        beat(14'h30FE, 1'b0);
        beat(14'h00A5, 1'b0);
        chk("mid_halt", 32'(halt), 32'd1);
        beat(14'h3002, 1'b1);
        chk("run_halt",  32'(halt),     32'd0);
        chk("run_ready", 32'(ld_ready), 32'd0);
        fetch(11'd1, 14'h00A5, "t2_a1");
        fetch(11'd0, 14'h30FE, "t2_a0");
        fetch(11'd2, 14'h3002, "t2_a2");

        // 3: oversize image on a 4-word memory
        start_load();
        for (int i = 0; i < 6; i++) begin
            beat(IMG3[i], (i == 5));
            if (i == 3) chk("t3_err_before", 32'(ld_err), 32'd0);
            if (i == 4) chk("t3_err_after",  32'(ld_err), 32'd1);
        end
        chk("t3_halt", 32'(halt), 32'd0);
        fetch(11'd0, IMG3[0], "t3_a0");
        fetch(11'd1, IMG3[1], "t3_a1");
        fetch(11'd2, IMG3[2], "t3_a2");
        fetch(11'd3, IMG3[3], "t3_a3");
        fetch(11'd5, 14'h0000, "t3_a5");
        fetch(11'd4, 14'h0000, "t3_a4");
        fetch(11'h7FF, 14'h0000, "t3_a7ff");
        chk("t3_err_sticky", 32'(ld_err), 32'd1);

        // 4: reload from RUN with a coincident beat and an in-flight fetch
        @(negedge clk);
        ld_start   = 1'b1;
        ld_valid   = 1'b1;
        ld_data    = 14'h3FFF;
        ld_last    = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 11'd1;
        exp_q.push_back(IMG3[1]);
        @(posedge clk);
        #1;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        ld_last   = 1'b0;
        fetch_req = 1'b0;
        chk("t4_halt_edge", 32'(halt),     32'd1);
        chk("t4_ready",     32'(ld_ready), 32'd1);
        check_out("t4_inflight");
        @(posedge clk);
        #1;
        chk("t4_beat_dropped", 32'(halt), 32'd1);
        chk("t4_idle_vld",     32'(fetch_vld), 32'd0);
        beat({OP_GOTO, 11'd5}, 1'b0);
        beat(14'h0123, 1'b1);
        chk("t4_run", 32'(halt), 32'd0);
        fetch(11'd0, 14'h2805, "t4_a0");
        fetch(11'd1, 14'h0123, "t4_a1");
        fetch(11'd2, IMG3[2], "t4_a2");

        // 5: asynchronous reset part-way through a load
        start_load();
        beat(14'h0AAA, 1'b0);
        beat(14'h0BBB, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_halt",     32'(halt),      32'd1);
        chk("t5_ready",    32'(ld_ready),  32'd0);
        chk("t5_ld_err",   32'(ld_err),    32'd0);
        chk("t5_vld",      32'(fetch_vld), 32'd0);
        $display("async reset halt=%b ld_ready=%b", halt, ld_ready);
        @(negedge clk);
        rst_n      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 11'd0;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        chk("t5_blocked_vld",  32'(fetch_vld),  32'd0);
        chk("t5_blocked_data", 32'(fetch_data), 32'h0000);
        chk("t5_idle_ready",   32'(ld_ready),   32'd0);
        chk("t5_idle_halt",    32'(halt),       32'd1);

        // 6: parity
`ifdef PROG_MEM_PARITY_EN
        start_load();
        beat(14'h30FE, 1'b0);
        beat(14'h00A5, 1'b0);
        beat(14'h3002, 1'b1);
        dut.u_array.mem[2] = dut.u_array.mem[2] ^ 15'h0008;
        fetch(11'd2, 14'h0000, "t6_bad");
        chk("t6_par_err", 32'(par_err), 32'd1);
        fetch(11'd0, 14'h30FE, "t6_good");
        chk("t6_par_sticky", 32'(par_err), 32'd1);
`else
        start_load();
        beat(14'h30FE, 1'b1);
        fetch(11'd0, 14'h30FE, "t6_word");
        chk("t6_par_tied", 32'(par_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_prog_mem_loadable
